// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Latency: 3-5 cycles per instruction plus memory wait cycles; outputs are combinational from state.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready; optional timeout abandons the wait.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // A zero timeout disables abandonment; the last legal wait count is N-1.
  localparam bit          TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t      st, st_nx;
  logic [15:0] wcnt;
  logic [1:0]  aluop;
  logic        waiting, tmo_hit, kill, op_known;
  logic        irw, pcw, rgw, mmw, done, ill;

  assign waiting  = (st == S_FETCH) || (st == S_MEMREAD) || (st == S_MEMWRITE);
  // The Nth consecutive not-ready cycle gives up; a ready in that cycle still wins.
  assign tmo_hit  = TMO_EN && waiting && !mem_ready && (wcnt == TMO_LAST);
  assign kill     = reset | tmo_hit;
  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  assign state    = st;

  // Next-state selection; a timeout overrides the normal wait transitions.
  always_comb begin
    st_nx = st;
    case (st)
      S_FETCH:    if (mem_ready) st_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: st_nx = S_MEMADR;
          OP_R:         st_nx = S_EXECR;
          OP_I:         st_nx = S_EXECI;
          OP_BEQ:       st_nx = S_BEQ;
          OP_JAL:       st_nx = S_JAL;
          default:      st_nx = S_FETCH;
        endcase
      end
      S_MEMADR:   st_nx = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) st_nx = S_MEMWB;
      S_MEMWRITE: if (mem_ready) st_nx = S_FETCH;
      S_EXECR:    st_nx = S_ALUWB;
      S_EXECI:    st_nx = S_ALUWB;
      default:    st_nx = S_FETCH;
    endcase
    if (tmo_hit) st_nx = S_FETCH;
  end

  // State register and wait counter; the counter restarts whenever a wait state is (re)entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= S_FETCH;
      wcnt <= '0;
    end else begin
      st <= st_nx;
      if ((st_nx != st) || tmo_hit) wcnt <= '0;
      else if (waiting && !mem_ready) wcnt <= wcnt + 16'd1;
    end
  end

  // Per-state datapath selects and raw (ungated) enables.
  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluop     = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    irw = 1'b0; pcw = 1'b0; rgw = 1'b0; mmw = 1'b0; done = 1'b0; ill = 1'b0;
    case (st)
      S_FETCH: begin
        ALUSrcB = 2'b10; ResultSrc = 2'b10; irw = mem_ready; pcw = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01; ill = !op_known;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01; rgw = 1'b1; done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; mmw = 1'b1; done = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10; aluop = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; aluop = 2'b10;
      end
      S_ALUWB: begin
        rgw = 1'b1; done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10; aluop = 2'b01; pcw = zero; done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; pcw = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are suppressed while in reset and in the cycle a memory wait is abandoned.
  assign IRWrite     = irw  & ~kill;
  assign PCWrite     = pcw  & ~kill;
  assign RegWrite    = rgw  & ~kill;
  assign MemWrite    = mmw  & ~kill;
  assign instr_done  = done & ~kill;
  assign illegal_op  = ill  & ~reset;
  assign mem_timeout = tmo_hit & ~reset;

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU operation from the internal ALUOp class and the instruction function fields.
  always_comb begin
    case (aluop)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: instruction-level sequence model pushes per-cycle
// expectations; a negedge monitor pops and compares against the DUT outputs.
// Directed cases first, then randomized instructions, memory stalls and branch outcomes.
module tb_multicycle_controller;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic       instr_done, illegal_op, mem_timeout;
  logic [3:0] state;

  multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [6:0] en;     // IRWrite,PCWrite,RegWrite,MemWrite,instr_done,illegal_op,mem_timeout
    logic [1:0] imm;
    bit         c_alu, c_a, c_b, c_r, c_adr;
    logic [2:0] alu;
    logic [1:0] a, b, r;
    logic       adr;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [6:0] en_act;
      bit bad;
      e = q.pop_front();
      en_act = {IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_op, mem_timeout};
      bad = (state !== e.st) || (en_act !== e.en) || (ImmSrc !== e.imm) ||
            (e.c_alu && ALUControl !== e.alu) || (e.c_a && ALUSrcA !== e.a) ||
            (e.c_b && ALUSrcB !== e.b) || (e.c_r && ResultSrc !== e.r) ||
            (e.c_adr && AdrSrc !== e.adr);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s t=%0t got st=%0d en=%b imm=%b alu=%b a=%b b=%b r=%b adr=%b | want st=%0d en=%b imm=%b alu=%b a=%b b=%b r=%b adr=%b",
                 e.name, $time, state, en_act, ImmSrc, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                 e.st, e.en, e.imm, e.alu, e.a, e.b, e.r, e.adr);
      end
    end
  end

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Arithmetic an ALU-class instruction asks for.
  function automatic logic [2:0] alu_of(logic [31:0] w);
    case (w[14:12])
      3'b000:  return (w[5] && w[30]) ? 3'b001 : 3'b000;  // sub only for R-type
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t base(string n, logic [3:0] s, logic [6:0] en);
    exp_t e;
    e.name = n; e.st = s; e.en = en; e.imm = imm_of(op);
    e.c_alu = 0; e.c_a = 0; e.c_b = 0; e.c_r = 0; e.c_adr = 0;
    e.alu = 'x; e.a = 'x; e.b = 'x; e.r = 'x; e.adr = 'x;
    return e;
  endfunction

  // Fix the selects this step cares about; negative means don't care.
  function automatic exp_t sel(exp_t ei, int a, int b, int r, int adr, int alu);
    exp_t e = ei;
    if (a >= 0)   begin e.c_a = 1;   e.a = 2'(a);     end
    if (b >= 0)   begin e.c_b = 1;   e.b = 2'(b);     end
    if (r >= 0)   begin e.c_r = 1;   e.r = 2'(r);     end
    if (adr >= 0) begin e.c_adr = 1; e.adr = 1'(adr); end
    if (alu >= 0) begin e.c_alu = 1; e.alu = 3'(alu); end
    return e;
  endfunction

  function automatic exp_t fetch_e(string n, logic [6:0] en);
    return sel(base(n, 4'd0, en), 0, 2, 2, 0, 0);
  endfunction

  task automatic step(exp_t e, bit mr, bit z);
    mem_ready = mr;
    zero = z;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // A memory wait of n not-ready cycles; the TO-th consecutive one abandons the instruction.
  task automatic mem_wait(int n, exp_t wait_e, exp_t to_e, exp_t ready_e, output bit ok);
    ok = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (i == TO) begin
        step(to_e, 1'b0, rb());
        return;
      end
      step(wait_e, 1'b0, rb());
    end
    step(ready_e, 1'b1, rb());
    ok = 1'b1;
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, driven from its class.
  task automatic run_instr(logic [31:0] w, int fw, int mw, bit z, bit kill);
    bit ok;
    exp_t e;
    op = w[6:0]; funct3 = w[14:12]; funct7b5 = w[30];
    mem_wait(fw, fetch_e("fetch_wait", 7'b0), fetch_e("fetch_tmo", 7'b0000001),
             fetch_e("fetch", 7'b1100000), ok);
    if (!ok) return;
    e = sel(base("decode", 4'd1, 7'b0), 1, 1, -1, -1, 0);
    if (!(op inside {LW, SW, RT, IT, BQ, JL})) begin
      e.en = 7'b0000010;
      step(e, rb(), rb());
      return;
    end
    step(e, rb(), rb());
    if (op == LW || op == SW) begin
      step(sel(base("memadr", 4'd2, 7'b0), 2, 1, -1, -1, 0), rb(), rb());
      if (op == LW) begin
        e = sel(base("memread", 4'd3, 7'b0), -1, -1, 0, 1, -1);
        mem_wait(mw, e, sel(base("memread_tmo", 4'd3, 7'b0000001), -1, -1, 0, 1, -1), e, ok);
        if (ok) step(sel(base("memwb", 4'd4, 7'b0010100), -1, -1, 1, -1, -1), rb(), rb());
      end else if (kill) begin
        step(sel(base("memwrite_wait", 4'd5, 7'b0001000), -1, -1, 0, 1, -1), 1'b0, rb());
        reset = 1'b1;
        step(fetch_e("reset_mid", 7'b0), 1'b1, rb());
        step(fetch_e("reset_mid", 7'b0), 1'b1, rb());
        reset = 1'b0;
      end else begin
        mem_wait(mw, sel(base("memwrite_wait", 4'd5, 7'b0001000), -1, -1, 0, 1, -1),
                 sel(base("memwrite_tmo", 4'd5, 7'b0000001), -1, -1, 0, 1, -1),
                 sel(base("memwrite", 4'd5, 7'b0001100), -1, -1, 0, 1, -1), ok);
      end
    end else if (op == RT || op == IT) begin
      if (op == RT) step(sel(base("execr", 4'd6, 7'b0), 2, 0, -1, -1, int'(alu_of(w))), rb(), rb());
      else          step(sel(base("execi", 4'd7, 7'b0), 2, 1, -1, -1, int'(alu_of(w))), rb(), rb());
      step(sel(base("aluwb", 4'd8, 7'b0010100), -1, -1, 0, -1, -1), rb(), rb());
    end else if (op == BQ) begin
      step(sel(base("beq", 4'd9, {1'b0, z, 5'b00100}), 2, 0, 0, -1, 1), rb(), z);
    end else begin
      step(sel(base("jal", 4'd10, 7'b0100100), 1, 2, 0, -1, 0), rb(), rb());
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  o;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: o = LW;
      1: o = SW;
      2: begin o = RT; w[31:25] = {1'b0, w[30], 5'b0}; end
      3: o = IT;
      4: o = BQ;
      5: o = JL;
      default: begin
        o = 7'($urandom);
        while (o inside {LW, SW, RT, IT, BQ, JL}) o = 7'($urandom);
      end
    endcase
    w[6:0] = o;
    return w;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    op = LW; funct3 = 3'b010; funct7b5 = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    step(fetch_e("reset", 7'b0), 1'b1, 1'b1);
    step(fetch_e("reset", 7'b0), 1'b1, 1'b0);
    reset = 1'b0;

    run_instr(32'hFFC4A303, 0, 0, 0, 0);   // lw
    run_instr(32'h0064A423, 0, 0, 0, 0);   // sw
    run_instr(32'h00500133, 0, 0, 0, 0);   // add
    run_instr(32'h40500133, 0, 0, 0, 0);   // sub
    run_instr(32'h00000063, 0, 0, 1, 0);   // beq taken
    run_instr(32'h00000063, 0, 0, 0, 0);   // beq not taken
    run_instr(32'h0000006F, 0, 0, 0, 0);   // jal
    run_instr(32'h40100093, 3, 0, 0, 0);   // addi with bit30 set, 3 fetch stalls
    run_instr(32'hFFC4A303, 0, 9, 0, 0);   // lw, read times out
    run_instr(32'h0064A423, 0, 3, 0, 0);   // sw, 3 stalls then ready
    run_instr(32'h0064A423, 0, 9, 0, 0);   // sw, write times out
    run_instr(32'h00500133, 7, 0, 0, 0);   // fetch times out
    run_instr(32'h0064A423, 0, 0, 0, 1);   // reset during MEMWRITE
    run_instr(32'h0000007F, 0, 0, 0, 0);   // illegal opcode
    run_instr(32'h0050E133, 0, 0, 0, 0);   // or
    run_instr(32'h0050F133, 0, 0, 0, 0);   // and
    run_instr(32'h0050A133, 0, 0, 0, 0);   // slt

    for (int n = 0; n < 300; n++)
      run_instr(rand_instr(), rand_wait(), rand_wait(), rb(), ($urandom_range(0, 40) == 0));

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (q.size() != 0) begin
      $display("FAIL %0d expectations never checked", q.size());
      $fatal(1);
    end
    if (vectors == 0) begin
      $display("FAIL no vectors were compared");
      $fatal(1);
    end
    if (miscompares != 0) begin
      $display("FAIL %0d miscompares", miscompares);
      $fatal(1);
    end
    $display("PASS");
    $finish;
  end

endmodule
